// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 receiver feeding a first-word-fall-through FIFO,
// with sticky framing and overrun error flags.
module uart_rx_fifo #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BAUD    = 19200,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rxd,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               fe_err,
  output logic               ovr_err,
  input  logic               err_clr
);
  localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int TW  = $clog2(DIV + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  logic [1:0]       sync;
  logic             rxs, tick, push, fe_set, pop, full, wr;
  logic [TW-1:0]    tcnt;
  state_t           state;
  logic [3:0]       cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg, push_data;
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [7:0]       mem [2**FIFO_AW];
  assign rxs  = sync[1];
  assign tick = tcnt == TW'(DIV - 1);
  // Synchroniser resets high so release never looks like a start bit.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sync <= 2'b11;
      tcnt <= '0;
    end else begin
      sync <= {sync[0], rxd};
      tcnt <= tick ? '0 : tcnt + 1'b1;
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      push_data <= '0;
      fe_set    <= 1'b0;
    end else begin
      push   <= 1'b0;
      fe_set <= 1'b0;
      if (tick)
        case (state)
          IDLE: if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
          START: if (cnt == 4'd7) begin
            state <= rxs ? IDLE : DATA;
            cnt   <= '0;
            idx   <= '0;
          end else cnt <= cnt + 1'b1;
          DATA: if (cnt == 4'd15) begin
            shreg <= {rxs, shreg[7:1]};
            idx   <= idx + 1'b1;
            cnt   <= '0;
            if (idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
          STOP: if (cnt == 4'd15) begin
            push      <= rxs;
            push_data <= shreg;
            fe_set    <= !rxs;
            state     <= rxs ? IDLE : BRK;
          end else cnt <= cnt + 1'b1;
          BRK: if (rxs) state <= IDLE;
          default: state <= IDLE;
        endcase
    end
  assign fifo_count = wr_ptr - rd_ptr;
  assign full       = fifo_count[FIFO_AW];
  assign rd_valid   = fifo_count != '0;
  assign pop        = rd_en & rd_valid;
  assign wr         = push & (!full | pop);
  assign rd_data    = rd_valid ? mem[rd_ptr[FIFO_AW-1:0]] : '0;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fe_err  <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      wr_ptr  <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr  <= pop ? rd_ptr + 1'b1 : rd_ptr;
      fe_err  <= fe_set ? 1'b1 : err_clr ? 1'b0 : fe_err;
      ovr_err <= (push & full & !pop) ? 1'b1 : err_clr ? 1'b0 : ovr_err;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames at a scaled clock/baud (64 clocks per bit),
// checking FIFO contents, counts and error flags against hand-computed values.
module tb_uart_rx_fifo;
  localparam int BIT = 64;
  logic       clk = 1'b0, resetn = 1'b0, rxd = 1'b1, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, fe_err, ovr_err;
  logic [4:0] fifo_count;
  int         n_tests = 0, n_fail = 0;
  uart_rx_fifo #(.CLK_HZ(1_000_000), .BAUD(15625), .FIFO_AW(4)) dut (
    .clk(clk), .resetn(resetn), .rxd(rxd), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_count(fifo_count), .fe_err(fe_err),
    .ovr_err(ovr_err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (16) @(negedge clk);
  endtask
  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask
  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask
  initial begin
    logic found;
    repeat (3) @(negedge clk);
    check("rst_valid", rd_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_data", rd_data, 0);
    check("rst_flags", {fe_err, ovr_err}, 0);
    resetn = 1'b1;
    repeat (BIT) @(negedge clk);
    send_frame(8'hA5, 1'b1);
    check("a5_valid", rd_valid, 1);
    check("a5_data", rd_data, 8'hA5);
    check("a5_count", fifo_count, 1);
    check("a5_flags", {fe_err, ovr_err}, 0);
    pop_one();
    check("a5_pop_valid", rd_valid, 0);
    check("a5_pop_count", fifo_count, 0);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    rxd = 1'b1;
    repeat (10 * BIT) @(negedge clk);
    check("glitch_count", fifo_count, 0);
    check("glitch_fe", fe_err, 0);
    send_frame(8'h3C, 1'b0);
    check("fe_set", fe_err, 1);
    check("fe_count", fifo_count, 0);
    pulse_clr();
    check("fe_clr", fe_err, 0);
    send_frame(8'h81, 1'b1);
    check("81_count", fifo_count, 1);
    check("81_data", rd_data, 8'h81);
    check("81_fe", fe_err, 0);
    pop_one();
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
    check("full_count", fifo_count, 16);
    check("full_ovr", ovr_err, 1);
    for (int i = 0; i < 16; i++) begin
      check("drain_data", rd_data, i);
      pop_one();
    end
    check("drain_valid", rd_valid, 0);
    check("drain_ovr_sticky", ovr_err, 1);
    pulse_clr();
    check("ovr_clr", ovr_err, 0);
    for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b1);
    check("refill_count", fifo_count, 16);
    found = 1'b0;
    fork
      send_frame(8'h55, 1'b1);
      for (int i = 0; i < 800 && !found; i++) begin
        @(negedge clk);
        if (dut.push) begin
          found = 1'b1;
          rd_en = 1'b1;
          @(negedge clk);
          rd_en = 1'b0;
        end
      end
    join
    check("push_seen", found, 1);
    check("pp_full_count", fifo_count, 16);
    check("pp_full_ovr", ovr_err, 0);
    for (int i = 0; i < 16; i++) begin
      check("pp_data", rd_data, i < 15 ? 32'h41 + i : 32'h55);
      pop_one();
    end
    check("pp_empty", rd_valid, 0);
    send_frame(8'h11, 1'b1);
    check("pre_rst_count", fifo_count, 1);
    fork
      send_frame(8'h96, 1'b1);
      begin
        repeat (4 * BIT + 32) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_data", rd_data, 0);
        check("mid_rst_flags", {fe_err, ovr_err}, 0);
        repeat (10) @(negedge clk);
        resetn = 1'b1;
      end
    join
    repeat (10 * BIT) @(negedge clk);
    for (int i = 0; i < 20 && rd_valid; i++) pop_one();
    pulse_clr();
    send_frame(8'h5A, 1'b1);
    check("5a_count", fifo_count, 1);
    check("5a_data", rd_data, 8'h5A);
    check("5a_fe", fe_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
